// File: rtl/safety_island_boot_seq.sv
// rtl/safety_island_boot_seq.sv - preloaded-boot sequencer acting as register-bus master
// Writes bootmode, per-core entry points and fetch enables, then polls EOC with pacing/timeout.
module safety_island_boot_seq #(
  parameter int unsigned          NumCores        = 1,
  parameter int unsigned          AddrWidth       = 32,
  parameter int unsigned          DataWidth       = 32,
  parameter logic [AddrWidth-1:0] BootModeAddr    = 'h0000_0000,
  parameter logic [AddrWidth-1:0] EntryBaseAddr   = 'h0000_0004,
  parameter logic [AddrWidth-1:0] FetchEnBaseAddr = 'h0000_0044,
  parameter int unsigned          RegStride       = 4,
  parameter logic [AddrWidth-1:0] EocAddr         = 'h0000_0084,
  parameter int unsigned          PollCycles      = 16,
  parameter int unsigned          MaxPolls        = 1024
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic                          abort_i,
  input  logic [DataWidth-1:0]          bootmode_i,
  input  logic [NumCores*DataWidth-1:0] entry_point_i,
  output logic                          req_o,
  input  logic                          gnt_i,
  output logic [AddrWidth-1:0]          addr_o,
  output logic                          we_o,
  output logic [DataWidth/8-1:0]        be_o,
  output logic [DataWidth-1:0]          wdata_o,
  input  logic                          rvalid_i,
  input  logic [DataWidth-1:0]          rdata_i,
  input  logic                          err_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          error_o,
  output logic [1:0]                    error_code_o,
  output logic [DataWidth-2:0]          exit_status_o
);

  localparam int unsigned     CoreW    = (NumCores > 1) ? $clog2(NumCores) : 1;
  localparam logic [CoreW-1:0] LastCore = CoreW'(NumCores - 1);

  typedef enum logic [2:0] {
    IDLE, WR_BOOT, WR_ENTRY, WR_FETCH, POLL_WAIT, RD_EOC, DONE, ERROR
  } state_e;

  state_e                        state_q, state_d;
  logic                          req_q, req_d, we_q, we_d;
  logic                          pend_q, pend_d, abort_q, abort_d;
  logic                          done_q, done_d, error_q, error_d;
  logic [AddrWidth-1:0]          addr_q, addr_d;
  logic [DataWidth-1:0]          wdata_q, wdata_d;
  logic [NumCores*DataWidth-1:0] entry_q, entry_d;
  logic [CoreW-1:0]              core_q, core_d;
  logic [31:0]                   wait_q, wait_d, polls_q, polls_d;
  logic [1:0]                    code_q, code_d;
  logic [DataWidth-2:0]          exit_q, exit_d;

  logic                          issue, issue_we, fail;
  logic [AddrWidth-1:0]          issue_addr;
  logic [DataWidth-1:0]          issue_wdata;
  logic [1:0]                    fail_code;
  logic [CoreW-1:0]              core_nx;
  logic [31:0]                   polls_inc;

  function automatic logic [AddrWidth-1:0] core_addr(input logic [AddrWidth-1:0] base,
                                                     input logic [CoreW-1:0] k);
    return base + AddrWidth'(RegStride) * AddrWidth'(k);
  endfunction

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    pend_d      = pend_q;
    abort_d     = abort_q;
    done_d      = done_q;
    error_d     = error_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    entry_d     = entry_q;
    core_d      = core_q;
    wait_d      = wait_q;
    polls_d     = polls_q;
    code_d      = code_q;
    exit_d      = exit_q;
    issue       = 1'b0;
    issue_we    = 1'b1;
    issue_addr  = '0;
    issue_wdata = '0;
    fail        = 1'b0;
    fail_code   = 2'd0;
    core_nx     = core_q + CoreW'(1);
    polls_inc   = polls_q + 32'd1;

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start_i) begin
          entry_d     = entry_point_i;
          done_d      = 1'b0;
          error_d     = 1'b0;
          code_d      = 2'd0;
          exit_d      = '0;
          polls_d     = '0;
          wait_d      = '0;
          core_d      = '0;
          abort_d     = 1'b0;
          pend_d      = 1'b0;
          state_d     = WR_BOOT;
          issue       = 1'b1;
          issue_addr  = BootModeAddr;
          issue_wdata = bootmode_i;
        end
      end
      POLL_WAIT: begin
        if (abort_i) begin
          fail      = 1'b1;
          fail_code = 2'd3;
        end else if (wait_q == 32'(PollCycles - 1)) begin
          state_d    = RD_EOC;
          issue      = 1'b1;
          issue_we   = 1'b0;
          issue_addr = EocAddr;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      default: begin
        if (req_q) begin
          // A grant in the same cycle as abort still commits the access, so defer the abort.
          if (gnt_i) begin
            req_d   = 1'b0;
            pend_d  = 1'b1;
            abort_d = abort_i;
          end else if (abort_i) begin
            fail      = 1'b1;
            fail_code = 2'd3;
          end
        end else if (pend_q) begin
          if (abort_i) abort_d = 1'b1;
          if (rvalid_i) begin
            pend_d  = 1'b0;
            abort_d = 1'b0;
            if (err_i) begin
              fail      = 1'b1;
              fail_code = 2'd1;
            end else if (abort_q || abort_i) begin
              fail      = 1'b1;
              fail_code = 2'd3;
            end else begin
              case (state_q)
                WR_BOOT: begin
                  state_d     = WR_ENTRY;
                  core_d      = '0;
                  issue       = 1'b1;
                  issue_addr  = EntryBaseAddr;
                  issue_wdata = entry_q[DataWidth-1:0];
                end
                WR_ENTRY: begin
                  issue = 1'b1;
                  if (core_q == LastCore) begin
                    state_d     = WR_FETCH;
                    core_d      = '0;
                    issue_addr  = FetchEnBaseAddr;
                    issue_wdata = DataWidth'(32'h1);
                  end else begin
                    core_d      = core_nx;
                    issue_addr  = core_addr(EntryBaseAddr, core_nx);
                    issue_wdata = entry_q[core_nx*DataWidth +: DataWidth];
                  end
                end
                WR_FETCH: begin
                  if (core_q == LastCore) begin
                    state_d = POLL_WAIT;
                    wait_d  = '0;
                  end else begin
                    core_d      = core_nx;
                    issue       = 1'b1;
                    issue_addr  = core_addr(FetchEnBaseAddr, core_nx);
                    issue_wdata = DataWidth'(32'h1);
                  end
                end
                RD_EOC: begin
                  polls_d = polls_inc;
                  if (rdata_i[DataWidth-1]) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    exit_d  = rdata_i[DataWidth-2:0];
                  end else if ((MaxPolls != 0) && (polls_inc == 32'(MaxPolls))) begin
                    fail      = 1'b1;
                    fail_code = 2'd2;
                  end else begin
                    state_d = POLL_WAIT;
                    wait_d  = '0;
                  end
                end
                default: ;
              endcase
            end
          end
        end
      end
    endcase

    if (issue) begin
      req_d   = 1'b1;
      we_d    = issue_we;
      addr_d  = issue_addr;
      wdata_d = issue_wdata;
    end
    if (fail) begin
      state_d = ERROR;
      error_d = 1'b1;
      code_d  = fail_code;
      req_d   = 1'b0;
      pend_d  = 1'b0;
      abort_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      pend_q  <= 1'b0;
      abort_q <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      entry_q <= '0;
      core_q  <= '0;
      wait_q  <= '0;
      polls_q <= '0;
      code_q  <= 2'd0;
      exit_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      pend_q  <= pend_d;
      abort_q <= abort_d;
      done_q  <= done_d;
      error_q <= error_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      entry_q <= entry_d;
      core_q  <= core_d;
      wait_q  <= wait_d;
      polls_q <= polls_d;
      code_q  <= code_d;
      exit_q  <= exit_d;
    end
  end

  assign req_o         = req_q;
  assign addr_o        = addr_q;
  assign we_o          = we_q;
  assign be_o          = '1;
  assign wdata_o       = wdata_q;
  assign busy_o        = (state_q != IDLE) && (state_q != DONE) && (state_q != ERROR);
  assign done_o        = done_q;
  assign error_o       = error_q;
  assign error_code_o  = code_q;
  assign exit_status_o = exit_q;

endmodule

// File: tb/tb_safety_island_boot_seq.sv
// tb/tb_safety_island_boot_seq.sv - randomized bus-slave bench with a transaction-list reference model
module tb_safety_island_boot_seq;
  localparam int NC = 2;
  localparam int PC = 3;
  localparam int MP = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_ni = 1'b0, start_i = 1'b0, abort_i = 1'b0;
  logic [31:0]    bootmode_i = '0;
  logic [NC*32-1:0] entry_point_i = '0;
  logic           req_o, gnt_i = 1'b0, we_o, rvalid_i = 1'b0, err_i = 1'b0;
  logic [31:0]    addr_o, wdata_o, rdata_i = '0;
  logic [3:0]     be_o;
  logic           busy_o, done_o, error_o;
  logic [1:0]     error_code_o;
  logic [30:0]    exit_status_o;

  safety_island_boot_seq #(.NumCores(NC), .PollCycles(PC), .MaxPolls(MP)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .bootmode_i(bootmode_i), .entry_point_i(entry_point_i),
    .req_o(req_o), .gnt_i(gnt_i), .addr_o(addr_o), .we_o(we_o), .be_o(be_o),
    .wdata_o(wdata_o), .rvalid_i(rvalid_i), .rdata_i(rdata_i), .err_i(err_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .error_code_o(error_code_o), .exit_status_o(exit_status_o));

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scenario description
  logic [31:0] s_boot, s_entry[NC], s_eoc[8];
  int s_err_at, s_abort_at, s_abort_mode, s_abort_poll_after, s_rst_after, s_gnt_fixed;
  bit s_spurious;

  // Model output
  logic [31:0] exp_addr[$], exp_wdata[$];
  bit exp_we[$];
  int exp_gap[$];
  bit exp_done, exp_err;
  logic [1:0] exp_code;
  logic [30:0] exp_exit;

  task automatic set_defaults();
    s_boot = $urandom;
    for (int c = 0; c < NC; c++) s_entry[c] = $urandom;
    for (int j = 0; j < 8; j++) s_eoc[j] = $urandom & 32'h7FFF_FFFF;
    s_err_at = -1; s_abort_at = -1; s_abort_mode = 0;
    s_abort_poll_after = -1; s_rst_after = -1; s_gnt_fixed = -1; s_spurious = 0;
  endtask

  task automatic push(input logic [31:0] a, input bit w, input logic [31:0] d, input int g);
    exp_addr.push_back(a); exp_we.push_back(w); exp_wdata.push_back(d); exp_gap.push_back(g);
  endtask

  // The expected bus trace is the full boot list, cut short by whichever interruption comes first.
  task automatic build_model();
    int n;
    exp_addr.delete(); exp_we.delete(); exp_wdata.delete(); exp_gap.delete();
    exp_done = 0; exp_err = 0; exp_code = 0; exp_exit = 0;
    push(32'h0, 1, s_boot, 0);
    for (int c = 0; c < NC; c++) push(32'h4 + 32'(4 * c), 1, s_entry[c], 0);
    for (int c = 0; c < NC; c++) push(32'h44 + 32'(4 * c), 1, 32'h1, 0);
    for (int j = 0; j < 8; j++) begin
      push(32'h84, 0, 32'h0, PC);
      if (s_eoc[j][31]) begin exp_done = 1; exp_exit = s_eoc[j][30:0]; break; end
      if (MP != 0 && j + 1 == MP) begin exp_err = 1; exp_code = 2; break; end
    end
    n = exp_addr.size();
    for (int i = 0; i < exp_addr.size(); i++) begin
      bool_poll: begin end
      if (i == s_err_at) begin n = i + 1; exp_done = 0; exp_err = 1; exp_code = 1; exp_exit = 0; break; end
      if (i == s_abort_at) begin n = i + 1; exp_done = 0; exp_err = 1; exp_code = 3; exp_exit = 0; break; end
      if (i + 1 < exp_addr.size() && exp_we[i + 1] == 0) begin
        if (i == s_abort_poll_after) begin n = i + 1; exp_done = 0; exp_err = 1; exp_code = 3; exp_exit = 0; break; end
        if (i == s_rst_after) begin n = i + 1; exp_done = 0; exp_err = 0; exp_code = 0; exp_exit = 0; break; end
      end
    end
    while (exp_addr.size() > n) begin
      void'(exp_addr.pop_back()); void'(exp_we.pop_back());
      void'(exp_wdata.pop_back()); void'(exp_gap.pop_back());
    end
  endtask

  // Every-cycle invariants on the status/bus outputs
  bit mon_en = 0;
  always @(negedge clk) if (mon_en) begin
    chk("be_all_ones", be_o, 4'hF);
    chk("status_exclusive", ($countones({busy_o, done_o, error_o}) <= 1), 1);
    chk("code_vs_error", (error_o == (error_code_o != 2'd0)), 1);
  end

  task automatic run_scn(input string tag);
    int idx, gap, d, lat, j;
    logic [31:0] sa, sd;
    bit sw, broke;
    build_model();
    @(negedge clk);
    start_i = 1; bootmode_i = s_boot;
    for (int c = 0; c < NC; c++) entry_point_i[c*32 +: 32] = s_entry[c];
    @(negedge clk);
    start_i = 0; bootmode_i = $urandom;
    for (int c = 0; c < NC; c++) entry_point_i[c*32 +: 32] = $urandom;
    chk({tag, "_start_clr"}, {done_o, error_o, error_code_o, exit_status_o}, '0);
    chk({tag, "_busy"}, busy_o, 1);
    idx = 0; broke = 0;
    while (idx < exp_addr.size() && !broke) begin
      gap = 0;
      while (!req_o && busy_o && gap < 100) begin @(negedge clk); gap++; end
      if (!req_o) begin chk({tag, "_req_missing"}, idx, exp_addr.size()); broke = 1; break; end
      chk({tag, "_gap"}, gap, exp_gap[idx]);
      chk({tag, "_addr"}, addr_o, exp_addr[idx]);
      chk({tag, "_we"}, we_o, exp_we[idx]);
      if (exp_we[idx]) chk({tag, "_wdata"}, wdata_o, exp_wdata[idx]);
      d = (idx == 0 && s_gnt_fixed >= 0) ? s_gnt_fixed : int'($urandom_range(0, 3));
      sa = addr_o; sd = wdata_o; sw = we_o;
      for (int k = 0; k < d; k++) begin
        if (idx == 0 && s_spurious) begin
          start_i = (k == 1); rvalid_i = (k == 2); err_i = (k == 2);
          bootmode_i = $urandom; rdata_i = 32'h8000_0000;
        end
        @(negedge clk);
        start_i = 0; rvalid_i = 0; err_i = 0;
        chk({tag, "_hold"}, {req_o, sw == we_o, sa == addr_o, sd == wdata_o}, 4'hF);
      end
      if (idx == s_abort_at && s_abort_mode == 1) begin
        abort_i = 1; @(negedge clk); abort_i = 0;
        chk({tag, "_abort_req_drop"}, req_o, 0);
        idx++; broke = 1; break;
      end
      gnt_i = 1; @(negedge clk); gnt_i = 0;
      chk({tag, "_req_drop"}, req_o, 0);
      lat = $urandom_range(0, 2);
      if (idx == s_abort_at && lat < 1) lat = 1;
      for (int k = 0; k < lat; k++) begin
        abort_i = (idx == s_abort_at && k == 0);
        @(negedge clk);
        abort_i = 0;
      end
      j = idx - (2 * NC + 1);
      rvalid_i = 1; err_i = (idx == s_err_at);
      rdata_i = (j >= 0) ? s_eoc[j] : $urandom;
      @(negedge clk);
      rvalid_i = 0; err_i = 0; rdata_i = $urandom;
      if (idx == s_abort_poll_after) begin
        abort_i = 1; @(negedge clk); abort_i = 0; idx++; broke = 1;
      end else if (idx == s_rst_after) begin
        rst_ni = 0; @(negedge clk); rst_ni = 1; idx++; broke = 1;
        chk({tag, "_rst_bus"}, {req_o, we_o, addr_o, wdata_o}, '0);
      end else begin
        idx++;
      end
    end
    chk({tag, "_txn_count"}, idx, exp_addr.size());
    chk({tag, "_busy_end"}, busy_o, 0);
    chk({tag, "_done"}, done_o, exp_done);
    chk({tag, "_error"}, error_o, exp_err);
    chk({tag, "_code"}, error_code_o, exp_code);
    chk({tag, "_exit"}, exit_status_o, exp_exit);
    for (int k = 0; k < PC + 3; k++) begin
      @(negedge clk);
      if (req_o) begin chk({tag, "_no_extra_req"}, req_o, 0); break; end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", {req_o, we_o, busy_o, done_o, error_o, error_code_o, exit_status_o}, '0);
    chk("reset_bus", {addr_o, wdata_o}, '0);
    rst_ni = 1;
    mon_en = 1;

    set_defaults(); s_eoc[0] = 0; s_eoc[1] = 0; s_eoc[2] = 32'h8000_0000;
    build_model();
    chk("pin_s1_len", exp_addr.size(), 8);
    chk("pin_s1_out", {exp_done, exp_err, exp_exit}, {1'b1, 1'b0, 31'h0});
    run_scn("two_polls_done");

    set_defaults(); s_eoc[0] = 32'h8000_002A;
    build_model();
    chk("pin_s2_exit", exp_exit, 31'h2A);
    run_scn("exit_2a");

    set_defaults(); for (int j = 0; j < 8; j++) s_eoc[j] = 32'h0000_1234;
    build_model();
    chk("pin_s3_len_code", {exp_addr.size(), exp_code}, {32'd9, 2'd2});
    run_scn("timeout");

    set_defaults(); s_err_at = 2;
    build_model();
    chk("pin_s4_len_code", {exp_addr.size(), exp_code}, {32'd3, 2'd1});
    run_scn("err_entry1");

    set_defaults(); s_gnt_fixed = 5; s_spurious = 1; s_eoc[0] = 32'h8000_0001;
    run_scn("gnt_withheld");

    set_defaults(); s_abort_at = 3;
    build_model();
    chk("pin_s6_len_code", {exp_addr.size(), exp_code}, {32'd4, 2'd3});
    run_scn("abort_fetch0_pending");

    set_defaults(); s_rst_after = 4;
    run_scn("reset_in_poll");

    set_defaults(); s_eoc[1] = 32'h8000_0ABC;
    run_scn("after_reset");

    set_defaults(); s_abort_at = 1; s_abort_mode = 1;
    run_scn("abort_before_gnt");

    set_defaults(); s_abort_poll_after = 5; s_eoc[2] = 32'h8000_0000;
    run_scn("abort_in_poll_wait");

    set_defaults(); s_err_at = 1; s_abort_at = 1;
    run_scn("err_beats_abort");

    for (int r = 0; r < 12; r++) begin
      set_defaults();
      for (int j = 0; j < 8; j++) if ($urandom_range(0, 2) == 0) s_eoc[j][31] = 1'b1;
      if ($urandom_range(0, 3) == 0) s_err_at = $urandom_range(0, 7);
      else if ($urandom_range(0, 3) == 0) begin
        s_abort_at = $urandom_range(0, 7); s_abort_mode = $urandom_range(0, 1);
      end
      run_scn("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
